// File: rtl/fetch_queue_if.sv
// Fetch queue port bundle: redirect input, memory req/gnt/rvalid port, IF/ID valid/ready port.
interface fetch_queue_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic            out_ready;
    logic [CW-1:0]   occupancy;

    // Queue side
    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  out_ready,
        output imem_req, imem_addr,
        output out_valid, out_pc, out_instr, occupancy
    );

    // Environment side (memory, EX redirect, IF/ID)
    modport slave (
        output redirect_valid, redirect_pc,
        output imem_gnt, imem_rvalid, imem_rdata,
        output out_ready,
        input  imem_req, imem_addr,
        input  out_valid, out_pc, out_instr, occupancy
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential word fetches, in-order {pc, instr} FIFO, redirect flush.
module fetch_queue #(
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master fq
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   inflight;   // every response still owed by memory, stale or not
    logic [CW-1:0]   drop_cnt;   // how many of those are stale
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    logic            issue;
    logic            rsp;
    logic            drop;
    logic            push;
    logic            pop;
    logic [SW-1:0]   credit_used;
    logic [XLEN-1:0] redirect_tgt;

    // Credit check, handshakes and head-of-queue outputs
    always_comb begin
        credit_used  = SW'(inflight) + SW'(count);
        redirect_tgt = fq.redirect_pc & ~XLEN'(3);

        fq.imem_req  = !rst && !fq.redirect_valid && (credit_used < SW'(DEPTH));
        fq.imem_addr = fetch_pc;
        issue        = fq.imem_req && fq.imem_gnt;

        rsp          = fq.imem_rvalid && (inflight != '0);
        drop         = rsp && (drop_cnt != '0);
        push         = rsp && (drop_cnt == '0) && !fq.redirect_valid;

        fq.out_valid = (count != '0) && !fq.redirect_valid;
        pop          = fq.out_valid && fq.out_ready;
        fq.out_pc    = (count != '0) ? pc_mem[rd_ptr]    : '0;
        fq.out_instr = (count != '0) ? instr_mem[rd_ptr] : '0;
        fq.occupancy = count;
    end

    // Fetch/response bookkeeping; a redirect marks everything still owed by memory as stale
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (fq.redirect_valid) begin
            fetch_pc <= redirect_tgt;
            resp_pc  <= redirect_tgt;
            inflight <= inflight - CW'(rsp);
            drop_cnt <= inflight - CW'(rsp);
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (push) begin
                resp_pc <= resp_pc + XLEN'(4);
                wr_ptr  <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (drop) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            inflight <= inflight + CW'(issue) - CW'(rsp);
            count    <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage, written only on an accepted live response
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_mem[wr_ptr]    <= resp_pc;
            instr_mem[wr_ptr] <= fq.imem_rdata;
        end
    end

    // Memory must never answer a fetch that was not issued
    assert property (@(posedge clk) disable iff (rst) !(fq.imem_rvalid && (inflight == '0)))
        else $error("fetch_queue: imem_rvalid with no fetch in flight");

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory model plus an epoch-based reference of delivered entries.
module tb_fetch_queue;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) fq ();

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .fq  (fq.master)
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        int unsigned epoch;
    } mreq_t;

    mreq_t       mq[$];     // requests owed by the memory, in order
    logic [31:0] mf[$];     // expected FIFO contents (addresses)
    logic [31:0] popq[$];   // PCs the DUT actually handed downstream
    int unsigned cyc;
    int unsigned epoch;
    logic [31:0] mfetch;
    int          n_chk;
    int          n_fail;
    bit          rand_gnt;
    bit          rand_ready;
    bit          ready_val;
    int unsigned lat_min;
    int unsigned lat_max;
    bit          last_ov;
    bit          last_req;
    logic [31:0] last_addr;
    int unsigned last_occ;
    int          first_k;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive memory/ready at negedge, check outputs, advance the reference
    task automatic step();
        mreq_t       r;
        bit          live;
        int unsigned due;
        @(negedge clk);
        fq.imem_rvalid = 1'b0;
        fq.imem_rdata  = '0;
        if (!rst && mq.size() != 0 && mq[0].due <= cyc) begin
            fq.imem_rvalid = 1'b1;
            fq.imem_rdata  = hash(mq[0].addr);
        end
        fq.imem_gnt  = rand_gnt   ? 1'($urandom_range(0, 1)) : 1'b1;
        fq.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
        #1;
        chk("imem_req", fq.imem_req,
            !rst && !fq.redirect_valid && ((mq.size() + mf.size()) < DEPTH));
        if (fq.imem_req) chk("imem_addr", fq.imem_addr, mfetch);
        chk("occupancy", fq.occupancy, mf.size());
        chk("out_valid", fq.out_valid, (mf.size() != 0) && !fq.redirect_valid);
        if (mf.size() != 0) begin
            chk("out_pc", fq.out_pc, mf[0]);
            chk("out_instr", fq.out_instr, hash(mf[0]));
        end else begin
            chk("out_pc_empty", fq.out_pc, 0);
            chk("out_instr_empty", fq.out_instr, 0);
        end
        last_ov   = fq.out_valid;
        last_req  = fq.imem_req;
        last_addr = fq.imem_addr;
        last_occ  = fq.occupancy;
        if (fq.out_valid && fq.out_ready) popq.push_back(fq.out_pc);

        if (rst) begin
            mq.delete();
            mf.delete();
            mfetch = 32'h0;
            epoch++;
        end else begin
            live = 1'b0;
            if (fq.imem_rvalid) begin
                r    = mq.pop_front();
                live = (r.epoch == epoch) && !fq.redirect_valid;
            end
            if (fq.redirect_valid) begin
                mf.delete();
                epoch++;
                mfetch = fq.redirect_pc & ~32'h3;
            end else begin
                if (mf.size() != 0 && fq.out_ready) void'(mf.pop_front());
                if (live) mf.push_back(r.addr);
                if (fq.imem_req && fq.imem_gnt) begin
                    due = cyc + $urandom_range(lat_min, lat_max);
                    if (mq.size() != 0 && due <= mq[$].due) due = mq[$].due + 1;
                    mq.push_back('{fq.imem_addr, due, epoch});
                    mfetch = mfetch + 32'd4;
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        rst               = 1'b1;
        fq.redirect_valid = 1'b0;
        fq.redirect_pc    = '0;
        fq.imem_gnt       = 1'b0;
        fq.imem_rvalid    = 1'b0;
        fq.imem_rdata     = '0;
        fq.out_ready      = 1'b0;
        rand_gnt = 0; rand_ready = 0; ready_val = 1;
        lat_min = 1; lat_max = 1;
        mfetch = 32'h0; cyc = 0; epoch = 0; n_chk = 0; n_fail = 0;

        // Reset
        repeat (3) step();
        rst = 1'b0;

        // Streaming with a 1-cycle memory
        first_k = -1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (last_ov && first_k < 0) first_k = k;
        end
        chk("first_out_valid_cycle", first_k, 2);

        // Back-pressure: queue saturates, requests stop
        ready_val = 0;
        repeat (20) step();
        chk("sat_occupancy", last_occ, 4);
        chk("sat_req_low", last_req, 0);
        ready_val = 1;
        repeat (10) step();
        for (int i = 0; i < popq.size(); i++) chk("seq_pc", popq[i], 32'(4 * i));

        // Redirect with stale responses outstanding (3-cycle memory)
        lat_min = 3; lat_max = 3;
        repeat (10) step();
        popq.delete();
        fq.redirect_valid = 1'b1; fq.redirect_pc = 32'h100;
        step();
        fq.redirect_valid = 1'b0;
        for (int i = 0; i < 40 && popq.size() < 2; i++) step();
        chk("p3_pop_count", popq.size() >= 2, 1);
        if (popq.size() >= 2) begin
            chk("p3_pc0", popq[0], 32'h100);
            chk("p3_pc1", popq[1], 32'h104);
        end

        // Unaligned redirect, minimum latency with a 1-cycle memory
        lat_min = 1; lat_max = 1;
        repeat (10) step();
        popq.delete();
        fq.redirect_valid = 1'b1; fq.redirect_pc = 32'h203;
        step();
        fq.redirect_valid = 1'b0;
        first_k = -1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 0) chk("p4_addr", last_addr, 32'h200);
            if (last_ov && first_k < 0) first_k = k;
        end
        chk("redirect_latency", first_k, 2);
        chk("p4_pop_count", popq.size() >= 2, 1);
        if (popq.size() >= 2) begin
            chk("p4_pc0", popq[0], 32'h200);
            chk("p4_pc1", popq[1], 32'h204);
        end

        // Back-to-back redirects, last one wins
        lat_min = 3; lat_max = 3;
        repeat (8) step();
        popq.delete();
        fq.redirect_valid = 1'b1; fq.redirect_pc = 32'h40;
        step();
        fq.redirect_pc = 32'h80;
        step();
        fq.redirect_valid = 1'b0;
        for (int i = 0; i < 40 && popq.size() < 3; i++) step();
        chk("p5_pop_count", popq.size() >= 3, 1);
        if (popq.size() >= 3) begin
            chk("p5_pc0", popq[0], 32'h80);
            chk("p5_pc1", popq[1], 32'h84);
            chk("p5_pc2", popq[2], 32'h88);
        end

        // Randomized traffic with occasional redirects
        rand_gnt = 1; rand_ready = 1; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 400; i++) begin
            fq.redirect_valid = ($urandom_range(0, 15) == 0);
            fq.redirect_pc    = $urandom;
            step();
        end
        fq.redirect_valid = 1'b0;
        rand_gnt = 0; rand_ready = 0; ready_val = 1; lat_min = 1; lat_max = 1;
        repeat (20) step();

        // Address wrap, then reset with a full queue
        ready_val = 0;
        fq.redirect_valid = 1'b1; fq.redirect_pc = 32'hFFFF_FFF8;
        step();
        fq.redirect_valid = 1'b0;
        step();
        chk("wrap_addr_m8", last_addr, 32'hFFFF_FFF8);
        step();
        chk("wrap_addr_m4", last_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr_0", last_addr, 32'h0);
        repeat (8) step();
        chk("full_occupancy", last_occ, 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("rst_out_valid", last_ov, 0);
        chk("rst_occupancy", last_occ, 0);
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
